boot_loader: RTL and testbench

- Hardware writer for the CPU's byte-wide instruction and data memories; replaces simulation-time preloading on silicon.
- Accepts a framed byte stream over a valid/ready interface and writes payload bytes, little-endian, into instruction or data memory.
- Holds Mips_Pipelined in reset until a RUN frame arrives, then releases it.
- Sits beside the CPU top, muxed onto the memory write ports while cpu_hold is high.

---
 rtl/boot_pkg.sv | 27 ++
 rtl/boot_loader.sv | 169 ++++++++++++++++
 tb/tb_boot_loader.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/boot_pkg.sv
// Shared constants and FSM encoding for the framed-stream memory boot loader.
package boot_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'h55;
    localparam logic [7:0] CMD_IMEM  = 8'h01;
    localparam logic [7:0] CMD_DMEM  = 8'h02;
    localparam logic [7:0] CMD_RUN   = 8'h03;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_CHK   = 2'b01;
    localparam logic [1:0] ERR_RANGE = 2'b10;
    localparam logic [1:0] ERR_CMD   = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CMD,
        S_A0,
        S_A1,
        S_L0,
        S_L1,
        S_DATA,
        S_CHK,
        S_ERR,
        S_RUNNING
    } state_t;

endpackage

// File: rtl/boot_loader.sv
// Framed byte-stream loader for IMEM/DMEM; holds the CPU in reset until a RUN frame.
// Write strobe 1 cycle after each DATA beat; in_ready drops only once RUNNING.
module boot_loader
    import boot_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int MEM_BYTES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              err,
    output logic [1:0]        err_code
);

    state_t      state, next_state;
    logic [15:0] base;
    logic [15:0] len;
    logic [15:0] idx;
    logic [7:0]  acc;
    logic        is_dmem;
    logic        is_run;

    logic        beat;
    logic [15:0] len_full;
    logic        range_bad;
    logic        err_set;
    logic [1:0]  err_val;

    assign beat     = in_valid && in_ready;
    assign in_ready = (state != S_RUNNING);
    assign cpu_hold = (state != S_RUNNING);
    assign busy     = !(state == S_IDLE || state == S_ERR || state == S_RUNNING);

    // Length as it stands on the L1 beat, before the high byte is registered.
    assign len_full  = {in_data, len[7:0]};
    assign range_bad = ({1'b0, base} + {1'b0, len_full}) > 17'(MEM_BYTES);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        err_set    = 1'b0;
        err_val    = ERR_NONE;
        if (beat) begin
            case (state)
                S_IDLE: if (in_data == SYNC_BYTE) next_state = S_CMD;
                S_CMD: begin
                    if (in_data == CMD_IMEM || in_data == CMD_DMEM) begin
                        next_state = S_A0;
                    end else if (in_data == CMD_RUN) begin
                        next_state = S_CHK;
                    end else begin
                        next_state = S_ERR;
                        err_set    = 1'b1;
                        err_val    = ERR_CMD;
                    end
                end
                S_A0: next_state = S_A1;
                S_A1: next_state = S_L0;
                S_L0: next_state = S_L1;
                S_L1: begin
                    if (range_bad) begin
                        next_state = S_ERR;
                        err_set    = 1'b1;
                        err_val    = ERR_RANGE;
                    end else if (len_full == 16'd0) begin
                        next_state = S_CHK;
                    end else begin
                        next_state = S_DATA;
                    end
                end
                S_DATA: if (idx == len - 16'd1) next_state = S_CHK;
                S_CHK: begin
                    if (in_data != acc) begin
                        next_state = S_ERR;
                        err_set    = 1'b1;
                        err_val    = ERR_CHK;
                    end else if (is_run) begin
                        next_state = S_RUNNING;
                    end else begin
                        next_state = S_IDLE;
                    end
                end
                S_ERR:     if (in_data == SYNC_BYTE) next_state = S_CMD;
                S_RUNNING: next_state = S_RUNNING;
                default:   next_state = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base      <= '0;
            len       <= '0;
            idx       <= '0;
            acc       <= '0;
            is_dmem   <= 1'b0;
            is_run    <= 1'b0;
            err       <= 1'b0;
            err_code  <= ERR_NONE;
            imem_we   <= 1'b0;
            dmem_we   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            imem_we <= 1'b0;
            dmem_we <= 1'b0;
            if (err_set) begin
                err      <= 1'b1;
                err_code <= err_val;
            end
            if (beat) begin
                case (state)
                    S_IDLE, S_ERR: begin
                        if (in_data == SYNC_BYTE) begin
                            acc      <= '0;
                            idx      <= '0;
                            err      <= 1'b0;
                            err_code <= ERR_NONE;
                        end
                    end
                    S_CMD: begin
                        acc     <= acc ^ in_data;
                        is_dmem <= (in_data == CMD_DMEM);
                        is_run  <= (in_data == CMD_RUN);
                    end
                    S_A0: begin
                        acc       <= acc ^ in_data;
                        base[7:0] <= in_data;
                    end
                    S_A1: begin
                        acc        <= acc ^ in_data;
                        base[15:8] <= in_data;
                    end
                    S_L0: begin
                        acc      <= acc ^ in_data;
                        len[7:0] <= in_data;
                    end
                    S_L1: begin
                        acc       <= acc ^ in_data;
                        len[15:8] <= in_data;
                    end
                    S_DATA: begin
                        acc       <= acc ^ in_data;
                        idx       <= idx + 16'd1;
                        imem_we   <= !is_dmem;
                        dmem_we   <= is_dmem;
                        mem_addr  <= base[ADDR_W-1:0] + idx[ADDR_W-1:0];
                        mem_wdata <= in_data;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_boot_loader.sv
// Scoreboard bench for boot_loader: frame-level reference model, randomized frames, monitor on strobes.
module tb_boot_loader;

    localparam int ADDR_W    = 10;
    localparam int MEM_BYTES = 1024;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_ready;
    logic              imem_we;
    logic              dmem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              cpu_hold;
    logic              busy;
    logic              err;
    logic [1:0]        err_code;

    int errors = 0;
    int checks = 0;

    // Expected writes: {is_dmem, addr, data}
    logic [18:0] sbq[$];
    logic [18:0] mon_e;
    logic [7:0]  pre[$];
    logic [7:0]  dbytes[$];
    logic [7:0]  fr[$];
    logic        exp_err;
    logic [1:0]  exp_code;

    boot_loader #(.ADDR_W(ADDR_W), .MEM_BYTES(MEM_BYTES)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .imem_we(imem_we), .dmem_we(dmem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .busy(busy), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst && (imem_we || dmem_we)) begin
            check("strobe_exclusive", {31'b0, imem_we & dmem_we}, 32'd0);
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got imem_we=%b dmem_we=%b addr=%0h data=%0h expected no write",
                         imem_we, dmem_we, mem_addr, mem_wdata);
            end else begin
                mon_e = sbq.pop_front();
                check("write", {13'b0, dmem_we, mem_addr, mem_wdata}, {13'b0, mon_e});
            end
        end
    end

    // Called just after a rising edge; leaves inputs idle just after the beat edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_err"}, {31'b0, err}, {31'b0, exp_err});
        check({tag, "_err_code"}, {30'b0, err_code}, {30'b0, exp_code});
        check({tag, "_busy"}, {31'b0, busy}, 32'd0);
        check({tag, "_cpu_hold"}, {31'b0, cpu_hold}, 32'd1);
        check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
        check({tag, "_sb_empty"}, sbq.size(), 32'd0);
    endtask

    // Frame-level reference: decides the outcome from the frame fields alone.
    task automatic do_frame(input string tag, input logic [7:0] cmd, input int base, input int len,
                            input bit bad_chk, input int gap);
        logic [7:0] x;
        logic [7:0] d;
        x = 8'h00;
        fr.delete();
        foreach (pre[i]) fr.push_back(pre[i]);
        pre.delete();
        fr.push_back(8'h55);
        fr.push_back(cmd);
        x ^= cmd;
        if (cmd != 8'h01 && cmd != 8'h02) begin
            exp_err  = 1'b1;
            exp_code = 2'b11;
        end else begin
            fr.push_back(base[7:0]);  x ^= base[7:0];
            fr.push_back(base[15:8]); x ^= base[15:8];
            fr.push_back(len[7:0]);   x ^= len[7:0];
            fr.push_back(len[15:8]);  x ^= len[15:8];
            if (base + len > MEM_BYTES) begin
                exp_err  = 1'b1;
                exp_code = 2'b10;
            end else begin
                for (int i = 0; i < len; i++) begin
                    d = (i < dbytes.size()) ? dbytes[i] : 8'($urandom_range(0, 255));
                    fr.push_back(d);
                    x ^= d;
                    sbq.push_back({cmd == 8'h02, 10'(base + i), d});
                end
                fr.push_back(bad_chk ? (x ^ 8'h01) : x);
                exp_err  = bad_chk;
                exp_code = bad_chk ? 2'b01 : 2'b00;
            end
        end
        dbytes.delete();
        foreach (fr[i]) send_byte(fr[i], gap);
        @(negedge clk);
        check_idle_outputs(tag);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] cmd;
        logic [7:0] g;
        int base, len, mode;
        exp_err  = 1'b0;
        exp_code = 2'b00;

        #12;
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_cpu_hold", {31'b0, cpu_hold}, 32'd1);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        check("rst_err_code", {30'b0, err_code}, 32'd0);
        check("rst_we", {30'b0, imem_we, dmem_we}, 32'd0);
        check("rst_addr", {22'b0, mem_addr}, 32'd0);
        check("rst_wdata", {24'b0, mem_wdata}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;

        dbytes = '{8'h20, 8'h08, 8'h01, 8'h24};
        do_frame("imem", 8'h01, 0, 4, 1'b0, 0);

        pre    = '{8'hAA, 8'h00};
        dbytes = '{8'h20, 8'h08, 8'h01, 8'h24};
        do_frame("stall", 8'h01, 0, 4, 1'b0, 3);

        dbytes = '{8'h20, 8'h08, 8'h01, 8'h24};
        do_frame("badchk", 8'h01, 0, 4, 1'b1, 0);

        dbytes = '{8'h7F};
        do_frame("recover", 8'h02, 16'h0010, 1, 1'b0, 0);

        do_frame("range", 8'h01, 16'h03FE, 4, 1'b0, 0);
        do_frame("badcmd", 8'h07, 0, 0, 1'b0, 0);
        do_frame("edge_fit", 8'h02, 1020, 4, 1'b0, 1);
        do_frame("len0", 8'h02, 5, 0, 1'b0, 0);
        do_frame("huge", 8'h01, 16'hFFF0, 16'h0020, 1'b0, 0);

        for (int n = 0; n < 40; n++) begin
            for (int k = $urandom_range(0, 2); k > 0; k--) begin
                g = 8'($urandom_range(0, 255));
                if (g == 8'h55) g = 8'h54;
                pre.push_back(g);
            end
            mode = $urandom_range(0, 9);
            cmd  = ($urandom_range(0, 1) == 1) ? 8'h02 : 8'h01;
            if (mode == 0) begin
                cmd  = 8'($urandom_range(4, 255));
                base = 0;
                len  = 0;
            end else if (mode == 1) begin
                base = $urandom_range(1000, 1023);
                len  = $urandom_range(1, 40);
            end else if (mode == 2) begin
                base = $urandom_range(0, 65535);
                len  = $urandom_range(0, 65535);
            end else begin
                base = $urandom_range(0, 1016);
                len  = $urandom_range(0, 8);
            end
            do_frame("rand", cmd, base, len, $urandom_range(0, 4) == 0, $urandom_range(0, 2));
        end

        // RUN frame: hold must drop on exactly the edge that accepts CHK.
        send_byte(8'h55, 0);
        send_byte(8'h03, 0);
        in_valid = 1'b1;
        in_data  = 8'h03;
        check("run_hold_before", {31'b0, cpu_hold}, 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        check("run_hold_after", {31'b0, cpu_hold}, 32'd0);
        check("run_in_ready", {31'b0, in_ready}, 32'd0);
        check("run_busy", {31'b0, busy}, 32'd0);
        check("run_err", {31'b0, err}, 32'd0);
        foreach (fr[i]) send_byte(8'h55 ^ 8'(i), 0);
        for (int i = 0; i < 8; i++) send_byte(8'($urandom_range(0, 255)), 0);
        @(negedge clk);
        check("run_stays_hold", {31'b0, cpu_hold}, 32'd0);
        check("run_stays_not_ready", {31'b0, in_ready}, 32'd0);
        check("run_sb_empty", sbq.size(), 32'd0);

        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("run_rst_hold", {31'b0, cpu_hold}, 32'd1);
        check("run_rst_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;

        // Reset while the second data strobe is still high.
        sbq.push_back({1'b0, 10'h001, 8'hA5});
        send_byte(8'h55, 0);
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h04, 0);
        send_byte(8'h00, 0);
        send_byte(8'hA5, 0);
        send_byte(8'h5A, 0);
        #1 rst = 1'b0;
        #1;
        check("midrst_imem_we", {31'b0, imem_we}, 32'd0);
        check("midrst_addr", {22'b0, mem_addr}, 32'd0);
        check("midrst_wdata", {24'b0, mem_wdata}, 32'd0);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_hold", {31'b0, cpu_hold}, 32'd1);
        check("midrst_ready", {31'b0, in_ready}, 32'd1);
        check("midrst_err", {31'b0, err}, 32'd0);
        check("midrst_sb_empty", sbq.size(), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        exp_err  = 1'b0;
        exp_code = 2'b00;
        do_frame("fresh", 8'h02, 16'h0100, 6, 1'b0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
